// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1 -- N-channel round-robin merge onto one registered output.
//
// N producers of WIDTH-bit words share a single consumer. A round-robin
// grant picks one requesting channel per transfer. The selected word is
// captured in one output register stage with a valid/ready handshake.
// The rotating pointer advances only when a word is actually taken.
//
// Optional feature (macro MUX_RR_FORCE_SEL_EN): adds force_en/force_sel,
// which restrict eligibility to one fixed channel (legacy fixed-select
// mux behaviour). Forced transfers do not move the round-robin pointer.
//
// Parameters:
//   WIDTH  data bits per channel (>= 1)
//   N      channel count (>= 2, any value)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_data    N*WIDTH channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   N  per-channel valid
//   in_ready   N  per-channel accept (one-hot or zero)
//   out_data   WIDTH registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data
//   out_sel    index of the channel that produced out_data
//   force_en   (MUX_RR_FORCE_SEL_EN only) restrict grant to force_sel
//   force_sel  (MUX_RR_FORCE_SEL_EN only) forced channel index

module mux_rr_nx1 #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_sel
`ifdef MUX_RR_FORCE_SEL_EN
  ,
  input  logic                   force_en,
  input  logic [$clog2(N)-1:0]   force_sel
`endif
);

  localparam int          SELW = $clog2(N);
  localparam int unsigned NU   = N;

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  gsel;
  logic             found;
  logic             forced;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  // Channel index base+k, wrapped at N (N need not be a power of two).
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                               input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NU) s = s - NU;
    return s[SELW-1:0];
  endfunction

  assign load = !out_valid || out_ready;

  // Grant: first valid channel scanning from ptr upward with wrap.
  always_comb begin
    found  = 1'b0;
    gsel   = '0;
    forced = 1'b0;
`ifdef MUX_RR_FORCE_SEL_EN
    if (force_en) begin
      forced = 1'b1;
      gsel   = force_sel;
      // Out-of-range force index grants nothing.
      if (32'(force_sel) < NU) found = in_valid[force_sel];
    end else begin
      for (int unsigned k = 0; k < NU; k++) begin
        if (!found && in_valid[wrap_add(ptr, k)]) begin
          found = 1'b1;
          gsel  = wrap_add(ptr, k);
        end
      end
    end
`else
    for (int unsigned k = 0; k < NU; k++) begin
      if (!found && in_valid[wrap_add(ptr, k)]) begin
        found = 1'b1;
        gsel  = wrap_add(ptr, k);
      end
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (gsel == SELW'(i)) begin
        sel_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load && found && !reset;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= gsel;
        if (!forced) begin
          if (32'(gsel) == NU - 1) ptr <= '0;
          else                     ptr <= gsel + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux_rr_nx1.md
Name: mux_rr_nx1

Overview:
- Parametrised successor to the datapath 2:1 select muxes: N channels of WIDTH bits merged onto one registered output with valid/ready handshakes.
- Round-robin arbitration picks among requesting channels; one output register stage.
- Used where several producers share one consumer, e.g. the writeback result merge or the memory request port.
- Fixed-select (legacy mux) behaviour is available through the optional feature.

Parameters:
- WIDTH, 8, data bits per channel; WIDTH >= 1.
- N, 4, channel count; N >= 2, need not be a power of two.
- SELW, $clog2(N), select/pointer width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i has data.
- in_ready  output  N  channel i is accepted this cycle.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data.
- out_sel  output  SELW  index of the channel that produced out_data.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
  - in_ready is forced to all-zero while reset is high.
- load = !out_valid || out_ready. This is the combinational output-register enable.
- Grant (combinational):
  - Scan channels ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - The first channel with in_valid=1 wins (g). At most one grant bit is set.
  - in_ready[i] = load && grant[i] && !reset.
  - in_ready never depends on the granted channel's own ready-to-valid path, so there are no combinational loops beyond in_valid → in_ready.
- On a clock edge with load=1 and some valid channel:
  - out_data <= channel g data; out_sel <= g; out_valid <= 1.
  - ptr <= (g == N-1) ? 0 : g+1. The pointer moves only on a transfer.
- On a clock edge with load=1 and no valid channel: out_valid <= 0. out_data, out_sel and ptr hold.
- On a clock edge with load=0 (out_valid=1, out_ready=0): all state holds and in_ready is all-zero.
- Latency: input transfer to out_valid is 1 cycle. Throughput is 1 word/cycle while out_ready=1.
- Simultaneous out_ready=1 and new input on the same edge: the old word is consumed and the new word is loaded; no bubble.
- Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,… Any valid channel waits at most N-1 transfers.
- Non-power-of-2 N: ptr never takes values ≥ N, and the scan wraps at N-1.
- Channel-side rule: a channel must hold in_valid and data until in_ready. The block does not check this. If a channel drops in_valid before grant, it simply loses eligibility.
- Reset mid-transfer: the pending output word is discarded and no channel sees in_ready; the block restarts from ptr=0.

Optional Feature:
- Macro: MUX_RR_FORCE_SEL_EN.
- Defined: adds ports force_en (input, 1) and force_sel (input, SELW).
  - When force_en=1, only channel force_sel is eligible. grant = in_valid[force_sel] at that index; all other channels get in_ready=0.
  - ptr is not updated on forced transfers.
  - force_sel ≥ N grants nothing.
  - force_en=0 gives normal round-robin.
- Undefined: the ports do not exist and behaviour is pure round-robin.

Test Plan:
- Reset check:
  - Stimulus: assert reset mid-stream with out_valid=1, and check during reset.
  - Required response: out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately (async). After release with in_valid=4'b0100, data 8'h5A: in_ready[2]=1, and the next cycle gives out_data=8'h5A, out_sel=2.
- Round-robin:
  - Stimulus: N=4, in_valid=4'b1111 held, out_ready=1, data channel i = 8'h10+i.
  - Required response: out_sel sequence 0,1,2,3,0,… with out_data 8'h10,8'h11,8'h12,8'h13.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1 (out_data=8'h11).
  - Required response: out_data stays 8'h11 and in_ready=0. On out_ready=1, the next word loads on the same edge with no idle cycle.
- Skip and wrap:
  - Stimulus: ptr=3, in_valid=4'b0010.
  - Required response: grant goes to channel 1, then ptr=2. Next, in_valid=4'b1001 grants channel 3.
- Non-power-of-2:
  - Stimulus: N=3, all valid, 7 transfers.
  - Required response: out_sel 0,1,2,0,1,2,0; out_sel never reaches 3.
- Force (MUX_RR_FORCE_SEL_EN):
  - Stimulus: force_en=1, force_sel=2, in_valid=4'b0111.
  - Required response: only channel 2 is granted repeatedly and ptr does not change. After force_en=0, grants resume from the prior ptr.
